// File: rtl/jpeg_pkg.sv
// Shared constants for the DCT quantize/zigzag stage.
//   ZZ            : zigzag position -> raster index (row*8 + col)
//   Q_LUMA/CHROMA : JPEG Annex K quality-50 quantizer tables, raster order
//   RECIP_*       : round(2^16 / Q) per raster index, folded at elaboration
//   state_t       : block FSM encoding
package jpeg_pkg;

  localparam int unsigned COEF_W_DEFAULT  = 8;
  localparam int unsigned RECIP_W_DEFAULT = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int unsigned ZZ [0:63] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam int unsigned Q_LUMA [0:63] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  localparam int unsigned Q_CHROMA [0:63] = '{
    17,  18,  24,  47,  99,  99,  99,  99,
    18,  21,  26,  66,  99,  99,  99,  99,
    24,  26,  56,  99,  99,  99,  99,  99,
    47,  66,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99
  };

  // Round-to-nearest reciprocal; only evaluated on constants.
  function automatic int unsigned rcp(input int unsigned q);
    return ((32'd1 << RECIP_W_DEFAULT) + q / 32'd2) / q;
  endfunction

  localparam int unsigned RECIP_LUMA [0:63] = '{
    rcp(Q_LUMA[ 0]), rcp(Q_LUMA[ 1]), rcp(Q_LUMA[ 2]), rcp(Q_LUMA[ 3]), rcp(Q_LUMA[ 4]), rcp(Q_LUMA[ 5]), rcp(Q_LUMA[ 6]), rcp(Q_LUMA[ 7]),
    rcp(Q_LUMA[ 8]), rcp(Q_LUMA[ 9]), rcp(Q_LUMA[10]), rcp(Q_LUMA[11]), rcp(Q_LUMA[12]), rcp(Q_LUMA[13]), rcp(Q_LUMA[14]), rcp(Q_LUMA[15]),
    rcp(Q_LUMA[16]), rcp(Q_LUMA[17]), rcp(Q_LUMA[18]), rcp(Q_LUMA[19]), rcp(Q_LUMA[20]), rcp(Q_LUMA[21]), rcp(Q_LUMA[22]), rcp(Q_LUMA[23]),
    rcp(Q_LUMA[24]), rcp(Q_LUMA[25]), rcp(Q_LUMA[26]), rcp(Q_LUMA[27]), rcp(Q_LUMA[28]), rcp(Q_LUMA[29]), rcp(Q_LUMA[30]), rcp(Q_LUMA[31]),
    rcp(Q_LUMA[32]), rcp(Q_LUMA[33]), rcp(Q_LUMA[34]), rcp(Q_LUMA[35]), rcp(Q_LUMA[36]), rcp(Q_LUMA[37]), rcp(Q_LUMA[38]), rcp(Q_LUMA[39]),
    rcp(Q_LUMA[40]), rcp(Q_LUMA[41]), rcp(Q_LUMA[42]), rcp(Q_LUMA[43]), rcp(Q_LUMA[44]), rcp(Q_LUMA[45]), rcp(Q_LUMA[46]), rcp(Q_LUMA[47]),
    rcp(Q_LUMA[48]), rcp(Q_LUMA[49]), rcp(Q_LUMA[50]), rcp(Q_LUMA[51]), rcp(Q_LUMA[52]), rcp(Q_LUMA[53]), rcp(Q_LUMA[54]), rcp(Q_LUMA[55]),
    rcp(Q_LUMA[56]), rcp(Q_LUMA[57]), rcp(Q_LUMA[58]), rcp(Q_LUMA[59]), rcp(Q_LUMA[60]), rcp(Q_LUMA[61]), rcp(Q_LUMA[62]), rcp(Q_LUMA[63])
  };

  localparam int unsigned RECIP_CHROMA [0:63] = '{
    rcp(Q_CHROMA[ 0]), rcp(Q_CHROMA[ 1]), rcp(Q_CHROMA[ 2]), rcp(Q_CHROMA[ 3]), rcp(Q_CHROMA[ 4]), rcp(Q_CHROMA[ 5]), rcp(Q_CHROMA[ 6]), rcp(Q_CHROMA[ 7]),
    rcp(Q_CHROMA[ 8]), rcp(Q_CHROMA[ 9]), rcp(Q_CHROMA[10]), rcp(Q_CHROMA[11]), rcp(Q_CHROMA[12]), rcp(Q_CHROMA[13]), rcp(Q_CHROMA[14]), rcp(Q_CHROMA[15]),
    rcp(Q_CHROMA[16]), rcp(Q_CHROMA[17]), rcp(Q_CHROMA[18]), rcp(Q_CHROMA[19]), rcp(Q_CHROMA[20]), rcp(Q_CHROMA[21]), rcp(Q_CHROMA[22]), rcp(Q_CHROMA[23]),
    rcp(Q_CHROMA[24]), rcp(Q_CHROMA[25]), rcp(Q_CHROMA[26]), rcp(Q_CHROMA[27]), rcp(Q_CHROMA[28]), rcp(Q_CHROMA[29]), rcp(Q_CHROMA[30]), rcp(Q_CHROMA[31]),
    rcp(Q_CHROMA[32]), rcp(Q_CHROMA[33]), rcp(Q_CHROMA[34]), rcp(Q_CHROMA[35]), rcp(Q_CHROMA[36]), rcp(Q_CHROMA[37]), rcp(Q_CHROMA[38]), rcp(Q_CHROMA[39]),
    rcp(Q_CHROMA[40]), rcp(Q_CHROMA[41]), rcp(Q_CHROMA[42]), rcp(Q_CHROMA[43]), rcp(Q_CHROMA[44]), rcp(Q_CHROMA[45]), rcp(Q_CHROMA[46]), rcp(Q_CHROMA[47]),
    rcp(Q_CHROMA[48]), rcp(Q_CHROMA[49]), rcp(Q_CHROMA[50]), rcp(Q_CHROMA[51]), rcp(Q_CHROMA[52]), rcp(Q_CHROMA[53]), rcp(Q_CHROMA[54]), rcp(Q_CHROMA[55]),
    rcp(Q_CHROMA[56]), rcp(Q_CHROMA[57]), rcp(Q_CHROMA[58]), rcp(Q_CHROMA[59]), rcp(Q_CHROMA[60]), rcp(Q_CHROMA[61]), rcp(Q_CHROMA[62]), rcp(Q_CHROMA[63])
  };

endpackage

// File: rtl/dct_quant_zigzag_if.sv
// Block-in / stream-out handshake bundle for dct_quant_zigzag.
//   in_valid/in_ready/qsel/coef_in[0:63] : parallel 8x8 block, row-major
//   out_valid/out_ready/out_data/out_pos/out_last : zigzag serial stream
// master = upstream producer + downstream consumer side, slave = the stage.
interface dct_quant_zigzag_if
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEFAULT
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     qsel;
  logic signed [COEF_W-1:0] coef_in [0:63];
  logic                     out_valid;
  logic                     out_ready;
  logic signed [COEF_W-1:0] out_data;
  logic [5:0]               out_pos;
  logic                     out_last;

  modport master (
    output in_valid, qsel, coef_in, out_ready,
    input  in_ready, out_valid, out_data, out_pos, out_last
  );

  modport slave (
    input  in_valid, qsel, coef_in, out_ready,
    output in_ready, out_valid, out_data, out_pos, out_last
  );
endinterface

// File: rtl/dct_quant_zigzag_quant_mul.sv
// Combinational reciprocal quantizer for one coefficient.
//   coef  : signed input coefficient
//   recip : round(2^RECIP_W / Q) for this coefficient's position
//   q     : signed quantized value, round-half-up on magnitude
module quant_mul #(
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned RECIP_W = 16
) (
  input  logic signed [COEF_W-1:0]  coef,
  input  logic        [RECIP_W-1:0] recip,
  output logic signed [COEF_W-1:0]  q
);
  localparam int unsigned PROD_W = COEF_W + RECIP_W;
  localparam logic [PROD_W:0] HALF    = (PROD_W+1)'(1) << (RECIP_W - 1);
  localparam logic [PROD_W:0] POS_MAX = (PROD_W+1)'({(COEF_W-1){1'b1}});
  localparam logic [PROD_W:0] NEG_MAX = (PROD_W+1)'(1) << (COEF_W - 1);

  logic              neg;
  logic [COEF_W-1:0] mag;
  logic [PROD_W-1:0] prod;
  logic [PROD_W:0]   rounded;
  logic [PROD_W:0]   q_mag;

  always_comb begin
    neg = coef[COEF_W-1];
    // Unsigned magnitude so the most negative input maps to 2^(COEF_W-1).
    mag     = neg ? $unsigned(-coef) : $unsigned(coef);
    prod    = PROD_W'(mag) * PROD_W'(recip);
    rounded = (PROD_W+1)'(prod) + HALF;
    q_mag   = rounded >> RECIP_W;
    if (neg) begin
      q = (q_mag > NEG_MAX) ? $signed(COEF_W'(NEG_MAX)) : -$signed(COEF_W'(q_mag));
    end else begin
      q = (q_mag > POS_MAX) ? $signed(COEF_W'(POS_MAX)) : $signed(COEF_W'(q_mag));
    end
  end
endmodule

// File: rtl/dct_quant_zigzag.sv
// Captures one 8x8 DCT block, quantizes each coefficient against the luma
// or chroma table and streams the results in JPEG zigzag order.
//   clock, reset : system clock, asynchronous active-high reset
//   io (slave)   : block input handshake and zigzag output stream
//   busy         : high while a block is held (RUN or DRAIN)
module dct_quant_zigzag
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W  = COEF_W_DEFAULT,
  parameter int unsigned RECIP_W = RECIP_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  dct_quant_zigzag_if.slave   io,
  output logic                busy
);
  state_t                   state, state_next;
  logic signed [COEF_W-1:0] coef_buf [0:63];
  logic                     sel;
  logic [5:0]               k;
  logic                     load, issue, retire, advance;
  logic [5:0]               raster;
  logic [RECIP_W-1:0]       recip;
  logic signed [COEF_W-1:0] q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    issue       = 1'b0;
    retire      = 1'b0;
    io.in_ready = 1'b0;
    // Output register may be refilled whenever it is empty or being taken.
    advance     = !io.out_valid || io.out_ready;
    case (state)
      S_IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (advance) begin
          issue = 1'b1;
          if (k == 6'd63) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (io.out_valid && io.out_ready) begin
          retire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (load) coef_buf <= io.coef_in;
  end

  always_comb begin
    raster = 6'(ZZ[k]);
    recip  = sel ? RECIP_W'(RECIP_CHROMA[raster]) : RECIP_W'(RECIP_LUMA[raster]);
  end

  quant_mul #(
    .COEF_W (COEF_W),
    .RECIP_W(RECIP_W)
  ) u_quant (
    .coef (coef_buf[raster]),
    .recip(recip),
    .q    (q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel          <= 1'b0;
      k            <= '0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_pos   <= '0;
      io.out_last  <= 1'b0;
    end else begin
      if (load) begin
        sel <= io.qsel;
        k   <= '0;
      end
      if (issue) begin
        io.out_data  <= q;
        io.out_pos   <= k;
        io.out_last  <= (k == 6'd63);
        io.out_valid <= 1'b1;
        k            <= k + 6'd1;
      end
      if (retire) io.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Self-checking bench for dct_quant_zigzag: a scoreboard of expected beats
// is filled when a block is driven and drained by a monitor on the stream.
module tb_dct_quant_zigzag;
  localparam int unsigned CW = 8;

  typedef struct {
    logic signed [7:0] data;
    logic [5:0]        pos;
    logic              last;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;

  dct_quant_zigzag_if #(.COEF_W(CW)) bus ();

  dct_quant_zigzag #(.COEF_W(CW), .RECIP_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  beat_t sb [$];
  int zz [0:63];
  logic signed [7:0] blk [0:63];

  int q_luma [0:63] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  int q_chroma [0:63] = '{
    17,  18,  24,  47,  99,  99,  99,  99,
    18,  21,  26,  66,  99,  99,  99,  99,
    24,  26,  56,  99,  99,  99,  99,  99,
    47,  66,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99
  };

  // Zigzag order built by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int idx, lo, hi;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[idx] = r * 8 + (s - r); idx++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[idx] = r * 8 + (s - r); idx++; end
      end
    end
  endfunction

  function automatic int model_q(int c, int qv);
    int m, r, q;
    m = (c < 0) ? -c : c;
    r = (65536 + qv / 2) / qv;
    q = (m * r + 32768) / 65536;
    if (c < 0) return -q;
    return (q > 127) ? 127 : q;
  endfunction

  task automatic push_block(input logic s);
    beat_t b;
    for (int k = 0; k < 64; k++) begin
      b.data = 8'(model_q(int'(blk[zz[k]]), s ? q_chroma[zz[k]] : q_luma[zz[k]]));
      b.pos  = 6'(k);
      b.last = (k == 63);
      sb.push_back(b);
    end
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom_range(0, 255));
  endtask

  // Returns at the falling edge after the accepting rising edge.
  task automatic drive_block(input logic s);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 300) begin @(negedge clock); n++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b required 1", bus.in_ready);
    end else begin
      bus.qsel = s;
      for (int i = 0; i < 64; i++) bus.coef_in[i] = blk[i];
      bus.in_valid = 1'b1;
      push_block(s);
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 2000) begin @(negedge clock); n++; end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_done busy=%b pending=%0d required busy=0 pending=0", name, busy, sb.size());
    end
  endtask

  // Scoreboard consumer: out_ready only changes just after rising edges,
  // so the falling-edge sample equals the value at the next handshake.
  always @(negedge clock) begin : monitor
    beat_t e;
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      beats++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat pos=%0d data=%0d required no beat", bus.out_pos, bus.out_data);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.out_data !== e.data) begin
          errors++;
          $display("FAIL beat_data pos=%0d got %0d required %0d", e.pos, bus.out_data, e.data);
        end
        checks++;
        if (bus.out_pos !== e.pos) begin
          errors++;
          $display("FAIL beat_pos got %0d required %0d", bus.out_pos, e.pos);
        end
        checks++;
        if (bus.out_last !== e.last) begin
          errors++;
          $display("FAIL beat_last pos=%0d got %b required %b", e.pos, bus.out_last, e.last);
        end
      end
    end
  end

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.qsel      = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) bus.coef_in[i] = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'sd0)  begin errors++; $display("FAIL rst_out_data got %0d required 0", bus.out_data); end
    checks++; if (bus.out_pos !== 6'd0)    begin errors++; $display("FAIL rst_out_pos got %0d required 0", bus.out_pos); end
    checks++; if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last got %b required 0", bus.out_last); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_zero_block();
    for (int i = 0; i < 64; i++) blk[i] = '0;
    drive_block(1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL first_latency out_valid=%b required 0", bus.out_valid); end
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pos !== 6'(i)) begin
        errors++;
        $display("FAIL zero_stream valid=%b pos=%0d required valid=1 pos=%0d", bus.out_valid, bus.out_pos, i);
      end
    end
    @(negedge clock);
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL zero_in_ready got %b required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid got %b required 0", bus.out_valid); end
  endtask

  task automatic test_values(input logic s);
    for (int i = 0; i < 64; i++) blk[i] = '0;
    blk[0]  = 8'sd100;
    blk[1]  = 8'sd33;
    blk[8]  = -8'sd24;
    blk[63] = 8'sd127;
    drive_block(s);
    wait_done("values_a");
    blk[0]  = -8'sd100;
    blk[2]  = -8'sd128;
    blk[63] = -8'sd128;
    drive_block(s);
    wait_done("values_b");
  endtask

  task automatic test_backpressure();
    int n;
    beat_t exp_b;
    rand_blk();
    beats = 0;
    bus.out_ready = 1'b1;
    drive_block(1'b0);
    n = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_pos === 6'd9) && n < 100) begin @(negedge clock); n++; end
    @(posedge clock); #1 bus.out_ready = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bp_pending got 0 required >0");
    end else begin
      exp_b = sb[0];
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pos !== 6'd10 || bus.out_data !== exp_b.data) begin
          errors++;
          $display("FAIL bp_freeze valid=%b pos=%0d data=%0d required 1/10/%0d",
                   bus.out_valid, bus.out_pos, bus.out_data, exp_b.data);
        end
      end
    end
    @(posedge clock); #1 bus.out_ready = 1'b1;
    wait_done("bp");
    checks++;
    if (beats != 64) begin errors++; $display("FAIL bp_beats got %0d required 64", beats); end
  endtask

  task automatic test_ignore_during_run();
    int n;
    rand_blk();
    drive_block(1'b0);
    n = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_pos === 6'd5) && n < 100) begin @(negedge clock); n++; end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL run_in_ready got %b required 0", bus.in_ready); end
    rand_blk();
    bus.qsel = 1'b1;
    for (int i = 0; i < 64; i++) bus.coef_in[i] = blk[i];
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    wait_done("ignore");
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_queued out_valid=%b busy=%b required 0/0", bus.out_valid, busy);
      end
    end
    drive_block(1'b1);
    wait_done("ignore_next");
  endtask

  task automatic test_reset_abort();
    int n;
    rand_blk();
    drive_block(1'b0);
    n = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_pos === 6'd30) && n < 100) begin @(negedge clock); n++; end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b required 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready got %b required 1", bus.in_ready); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL abort_busy got %b required 0", busy); end
    sb.delete();
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_residue out_valid=%b required 0", bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int b = 0; b < 4; b++) begin
      rand_blk();
      drive_block(1'($urandom_range(0, 1)));
      n = 0;
      while ((busy || sb.size() != 0) && n < 1000) begin
        @(posedge clock); #1 bus.out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
        errors++;
        $display("FAIL b2b_done busy=%b pending=%0d required 0/0", busy, sb.size());
      end
    end
    @(posedge clock); #1 bus.out_ready = 1'b1;
  endtask

  initial begin
    build_zz();
    test_reset();
    test_zero_block();
    test_values(1'b0);
    test_backpressure();
    test_ignore_during_run();
    test_reset_abort();
    test_values(1'b1);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
